// File: rtl/rr_pkg.sv
// Shared types and sizes for the round-robin grant sequencer.
package rr_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } rr_state_t;

endpackage

// File: rtl/rr_grant_sequencer_chk.sv
// Protocol checker for the grant sequencer outputs (dead cycle, timeout pulse, stable owner).
module rr_grant_sequencer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       gnt_valid,
  input logic [1:0] gnt_idx,
  input logic       timeout
);

  // A release is always followed by at least one cycle with no grant.
  a_dead_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    $fell(gnt_valid) |=> !gnt_valid);

  // Timeout is a single-cycle pulse coinciding with the grant dropping.
  a_timeout_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    timeout |=> !timeout);

  a_timeout_release : assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> $fell(gnt_valid));

  // The owner index cannot change underneath an active grant.
  a_owner_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_valid && $past(gnt_valid)) |-> $stable(gnt_idx));

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request scanning ptr+1 .. ptr+4 (mod 4).
import rr_pkg::*;

module rr_pick (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scan in priority order; the channel at ptr itself is checked last.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any && req[ptr + IDX_W'(k)]) begin
        any = 1'b1;
        idx = ptr + IDX_W'(k);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// 4-way round-robin arbiter driving a 2-to-4 channel decoder (gnt_idx[1]->x, gnt_idx[0]->y).
// Optional forced release after HOLD_MAX grant cycles when RR_TIMEOUT_EN is defined.
import rr_pkg::*;

module rr_grant_sequencer #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx,
  output logic       timeout
);

  rr_state_t        state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;
  logic             pick_any_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             owner_req_s;
  logic             release_s;
  logic             expire_s;

  if ((2 ** CNT_W) <= HOLD_MAX) begin : g_cfg_check
    $error("rr_grant_sequencer: CNT_W too narrow for HOLD_MAX");
  end

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // done and owner-abort share one release path, so both together release once.
  assign owner_req_s = req[gnt_idx_r];
  assign release_s   = done | ~owner_req_s;

`ifdef RR_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_r;
  logic             timeout_r;

  assign expire_s = (hold_cnt_r == CNT_W'(HOLD_MAX));
  assign timeout  = timeout_r;
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Arbitration FSM with registered grant outputs and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 2'd3;
      gnt_idx_r   <= 2'd0;
      gnt_valid_r <= 1'b0;
`ifdef RR_TIMEOUT_EN
      hold_cnt_r  <= '0;
      timeout_r   <= 1'b0;
`endif
    end else begin
`ifdef RR_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r     <= GRANT;
            gnt_idx_r   <= pick_idx_s;
            ptr_r       <= pick_idx_s;
            gnt_valid_r <= 1'b1;
`ifdef RR_TIMEOUT_EN
            hold_cnt_r  <= '0;
`endif
          end else begin
            state_r     <= IDLE;
            gnt_valid_r <= 1'b0;
          end
        end
        GRANT: begin
          if (release_s) begin
            state_r     <= RELEASE;
            gnt_valid_r <= 1'b0;
          end else if (expire_s) begin
            state_r     <= RELEASE;
            gnt_valid_r <= 1'b0;
`ifdef RR_TIMEOUT_EN
            timeout_r   <= 1'b1;
`endif
          end else begin
            state_r     <= GRANT;
            gnt_valid_r <= 1'b1;
`ifdef RR_TIMEOUT_EN
            hold_cnt_r  <= hold_cnt_r + CNT_W'(1);
`endif
          end
        end
        RELEASE: begin
          state_r     <= IDLE;
          gnt_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          gnt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_valid = gnt_valid_r;
  assign gnt_idx   = gnt_idx_r;

  rr_grant_sequencer_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Scoreboard bench for rr_grant_sequencer: directed scenarios plus random traffic
// against a transaction-level reference model. Honors RR_TIMEOUT_EN like the RTL.
module tb_rr_grant_sequencer;

  localparam int HOLD_MAX = 15;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   grants_q[$];
  int   to_seen = 0;
  logic prev_v = 1'b0;
  logic [3:0] dec;
  logic [3:0] edec;
  exp_t e;
  int   exp_seq[5] = '{0, 1, 2, 3, 0};

  // Reference model: who owns the channel, who was served last, how long held.
  int   m_owner;
  int   m_last;
  int   m_hold;
  int   m_idx;
  bit   m_dead;
  bit   m_to;

  always #5 clk = ~clk;

  rr_grant_sequencer #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
    m_idx   = 0;
    m_dead  = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_owner = -1;
        m_dead  = 1'b1;
      end else if (TO_EN && m_hold == HOLD_MAX) begin
        m_owner = -1;
        m_dead  = 1'b1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
    end else if (m_dead) begin
      m_dead = 1'b0;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && r[c]) m_owner = c;
      end
      m_last = m_owner;
      m_idx  = m_owner;
      m_hold = 0;
    end
  endtask

  function automatic exp_t model_out();
    exp_t o;
    o.valid = (m_owner >= 0);
    o.idx   = m_idx[1:0];
    o.to    = m_to;
    return o;
  endfunction

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    chk("reset_valid", gnt_valid, 0);
    chk("reset_idx", gnt_idx, 0);
    chk("reset_timeout", timeout, 0);
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    rst_n = 1'b1;
    model_step(4'b0000, 1'b0);
    exp_q.push_back(model_out());
  endtask

  // Monitor: pops one expectation per clock and checks outputs plus decoder one-hot.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (gnt_valid && !prev_v) grants_q.push_back(int'(gnt_idx));
      if (timeout) to_seen++;
      prev_v = gnt_valid;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_valid", gnt_valid, e.valid);
        chk("gnt_idx", gnt_idx, e.idx);
        chk("timeout", timeout, e.to);
        dec  = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
        edec = e.valid ? (4'b0001 << e.idx) : 4'b0000;
        chk("decoder_onehot", dec, edec);
      end
    end
  end

  initial begin : stim
    logic [3:0] r;
    logic       d;
    model_reset();
    do_reset();

    // Full request: strict rotation 0,1,2,3,0.
    grants_q.delete();
    for (int n = 0; n < 5; n++) begin
      step(4'hF, 1'b0);
      step(4'hF, 1'b0);
      step(4'hF, 1'b1);
      step(4'hF, 1'b0);
    end
    step(4'h0, 1'b0);
    chk("rr_order_len", grants_q.size(), 5);
    if (grants_q.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", grants_q[i], exp_seq[i]);
    end

    // Single requester: grant, release with one dead cycle, re-grant.
    step(4'h4, 1'b0);
    step(4'h4, 1'b0);
    step(4'h4, 1'b0);
    step(4'h4, 1'b1);
    step(4'h4, 1'b0);
    step(4'h4, 1'b0);
    step(4'h4, 1'b1);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    chk("regrant_count", grants_q.size(), 7);
    chk("regrant_idx", (grants_q.size() > 0) ? grants_q[$] : -1, 2);

    // Abort by dropping the owner's request.
    step(4'h2, 1'b0);
    step(4'h2, 1'b0);
    step(4'h2, 1'b0);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);

    // Long hold on ch3 without done.
    to_seen = 0;
    step(4'h8, 1'b0);
    repeat (16) step(4'h8, 1'b0);
    step(4'h9, 1'b0);
    step(4'h9, 1'b0);
    repeat (3) step(4'h9, 1'b0);
    step(4'h9, 1'b1);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    chk("timeout_pulses", to_seen, TO_EN ? 1 : 0);

    // Reset in the middle of a grant on ch2, then restart from ch0.
    do_reset();
    step(4'h4, 1'b0);
    step(4'h4, 1'b0);
    step(4'h4, 1'b0);
    do_reset();
    step(4'hC, 1'b0);
    step(4'hC, 1'b0);
    step(4'hC, 1'b1);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    chk("post_reset_grant", (grants_q.size() > 0) ? grants_q[$] : -1, 2);

    // done and owner drop together.
    step(4'h1, 1'b0);
    step(4'h1, 1'b0);
    step(4'h0, 1'b1);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);

    // Random traffic: frequent done first, then rare done to exercise long holds.
    r = 4'($urandom_range(0, 15));
    repeat (500) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0);
      step(r, d);
    end
    repeat (600) begin
      if ($urandom_range(0, 31) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 39) == 0);
      step(r, d);
    end

    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
